eth_fcs_check: RTL

Receive-side frame-integrity stage fed by the same serial stream (sck/sda/n_ss) as the receiver and MAC filter. It counts the bytes of the current frame, runs a bit-serial Ethernet CRC-32 over them, and takes the filter's n_inhibit into account. It presents a per-frame verdict (length, ok, error flags) that survives n_ss deassertion until the next frame starts. Software reads these status bits to decide whether the buffered frame is consumed or dropped.

---
 rtl/eth_fcs_check.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eth_fcs_check.sv
// eth_fcs_check
//   Receive-side frame-integrity stage. It watches the same serial stream as
//   the receiver and the MAC filter (sck/sda/n_ss). It counts the bytes of the
//   current frame and runs a bit-serial Ethernet CRC-32 over them. It also
//   honours the filter's n_inhibit. The per-frame verdict is held after n_ss
//   rises, until the first sck edge of the next frame.
//
// Optional feature macro: ETH_FCS_CHECK_EN
//   defined   : the CRC register and residue check are built.
//   undefined : the CRC is omitted and its term of rx_ok is treated as true.
//
// Parameters:
//   MIN_LEN      minimum legal frame length in bytes, FCS included
//   MAX_LEN      maximum legal frame length in bytes, FCS included (< 2048)
//
// Ports:
//   sck          serial bit clock; sda is sampled on its rising edge
//   n_rst        asynchronous active-low reset; clears everything
//   sda          serial data, LSB of each byte first
//   n_ss         frame select, active-low; high = no frame
//   n_inhibit    from eth_mac_filter; low = frame rejected
//   rx_len       completed bytes in the current/last frame (saturates at 2047)
//   rx_ok        frame good: CRC residue, length in range, not rejected
//   rx_busy      frame in progress (state RECV)
//   rx_runt      rx_len < MIN_LEN
//   rx_overflow  more than MAX_LEN bytes seen
//   rx_rejected  n_inhibit was sampled low during this frame
//
// Valid/ready note: this block has no handshake. Each sck rising edge taken
// while n_ss is low carries one data bit. The status outputs are a level
// verdict that software may read at any time while n_ss is high.
module eth_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        sck,
  input  logic        n_rst,
  input  logic        sda,
  input  logic        n_ss,
  input  logic        n_inhibit,
  output logic [10:0] rx_len,
  output logic        rx_ok,
  output logic        rx_busy,
  output logic        rx_runt,
  output logic        rx_overflow,
  output logic        rx_rejected
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT = 11'd2047;

  // The working registers are cleared by n_rst and also by n_ss high. This
  // matches the filter, which uses n_ss as a clear. Every sck edge that
  // reaches them therefore belongs to a selected frame.
  logic work_rst_n;
  assign work_rst_n = n_rst & ~n_ss;

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;

  logic [10:0] len_q, len_d;
  logic        ok_q, ok_d;
  logic        runt_q, runt_d;
  logic        ovf_q, ovf_d;
  logic        rej_q, rej_d;

  logic [10:0] len_inc;
  logic        len_in_range;
  logic        crc_match;

`ifdef ETH_FCS_CHECK_EN
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_q, crc_d, crc_next;

  // Reflected LFSR step for the bit sampled on this edge.
  assign crc_next  = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ sda) ? POLY : 32'h0);
  // A frame whose trailing FCS is correct leaves this constant residue.
  assign crc_match = (crc_next == RESIDUE);
`else
  // The data bits are not needed when the CRC is not built.
  logic unused_sda;
  assign unused_sda = sda;
  assign crc_match  = 1'b1;
`endif

  assign len_inc      = (len_q == LEN_SAT) ? LEN_SAT : len_q + 11'd1;
  assign len_in_range = (len_inc >= MIN_L) && (len_inc <= MAX_L);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    len_d    = len_q;
    ok_d     = ok_q;
    runt_d   = runt_q;
    ovf_d    = ovf_q;
    rej_d    = rej_q;
`ifdef ETH_FCS_CHECK_EN
    crc_d    = crc_q;
`endif
    // The status registers also see sck while n_ss is high, so that case must not
    // change them.
    if (!n_ss) begin
      case (state_q)
        IDLE: begin
          // The first bit of a new frame also starts a fresh verdict.
          state_d  = RECV;
          bitcnt_d = 3'd1;
          len_d    = 11'd0;
          ok_d     = 1'b0;
          runt_d   = 1'b1;
          ovf_d    = 1'b0;
          rej_d    = 1'b0;
`ifdef ETH_FCS_CHECK_EN
          crc_d    = crc_next;
`endif
        end
        RECV: begin
          bitcnt_d = bitcnt_q + 3'd1;
`ifdef ETH_FCS_CHECK_EN
          crc_d    = crc_next;
`endif
          if (bitcnt_q == 3'd7) begin
            len_d  = len_inc;
            runt_d = (len_inc < MIN_L);
            ok_d   = crc_match && len_in_range;
            if (len_inc > MAX_L) begin
              ovf_d   = 1'b1;
              ok_d    = 1'b0;
              state_d = STOP;
            end
          end
          // A rejection overrides the verdict. A byte that completes on the
          // same edge is still counted above.
          if (!n_inhibit) begin
            rej_d   = 1'b1;
            ok_d    = 1'b0;
            state_d = STOP;
          end
        end
        default: begin
          // STOP: ignore sda and freeze the verdict until n_ss rises.
        end
      endcase
    end
  end

  always_ff @(posedge sck or negedge work_rst_n) begin
    if (!work_rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
`ifdef ETH_FCS_CHECK_EN
      crc_q    <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
`ifdef ETH_FCS_CHECK_EN
      crc_q    <= crc_d;
`endif
    end
  end

  // The verdict is cleared only by n_rst, so it outlives the frame.
  always_ff @(posedge sck or negedge n_rst) begin
    if (!n_rst) begin
      len_q  <= 11'd0;
      ok_q   <= 1'b0;
      runt_q <= 1'b0;
      ovf_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      ok_q   <= ok_d;
      runt_q <= runt_d;
      ovf_q  <= ovf_d;
      rej_q  <= rej_d;
    end
  end

  assign rx_len      = len_q;
  assign rx_ok       = ok_q;
  assign rx_runt     = runt_q;
  assign rx_overflow = ovf_q;
  assign rx_rejected = rej_q;
  assign rx_busy     = (state_q == RECV);

endmodule
